// File: rtl/ccff_pkg.sv
// ccff_pkg: shared FSM state type and pass geometry helper for the config-chain loader
package ccff_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
  typedef struct packed {
    int words;
    int last_bits;
  } pass_geom_t;
  function automatic pass_geom_t pass_geom(input int chain_len, input int word_w);
    pass_geom_t g;
    g.words = (chain_len + word_w - 1) / word_w;
    g.last_bits = (chain_len % word_w == 0) ? word_w : chain_len % word_w;
    return g;
  endfunction
endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: buffers accepted words and shifts nbits of each MSB-first onto a registered head/enable pair
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int LW = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              allow,
  input  logic [LW-1:0]     nbits,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              take,
  output logic              head,
  output logic              clk_en
);
  logic [WORD_W-1:0] sh;
  logic [LW-1:0] left;
  assign word_ready = allow && left == '0;
  assign take = word_ready && word_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      left <= '0;
      head <= 1'b0;
      clk_en <= 1'b0;
    end else if (take) begin
      head <= word_in[WORD_W-1];
      clk_en <= 1'b1;
      sh <= word_in << 1;
      left <= nbits - LW'(1);
    end else if (left != '0) begin
      head <= sh[WORD_W-1];
      clk_en <= 1'b1;
      sh <= sh << 1;
      left <= left - LW'(1);
    end else
      clk_en <= 1'b0;
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: drives a config chain (ccff_head/ccff_clk_en) from a word stream, with optional readback pass
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CHAIN_LEN = 36,
  parameter bit VERIFY = 1'b1,
  parameter int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic [CNT_W-1:0]  bit_count
);
  localparam pass_geom_t GEOM = pass_geom(CHAIN_LEN, WORD_W);
  localparam int WORDS = GEOM.words;
  localparam int LAST = GEOM.last_bits;
  localparam int TOTAL = VERIFY ? 2 * WORDS : WORDS;
  localparam int LW = $clog2(WORD_W + 1);
  localparam int AW = $clog2(2 * WORDS + 1);
  state_t state, state_nx;
  logic [AW-1:0] acc;
  logic [LW-1:0] nbits;
  logic take, allow, last_bit, last_word, restart;
  assign busy = state == LOAD || state == CHECK;
  assign done = state == DONE;
  assign restart = start && (state == IDLE || state == DONE);
  assign allow = busy && acc < AW'(TOTAL);
  assign last_word = acc == AW'(WORDS - 1) || (VERIFY && acc == AW'(2 * WORDS - 1));
  assign nbits = last_word ? LW'(LAST) : LW'(WORD_W);
  assign last_bit = ccff_clk_en && bit_count == CNT_W'(CHAIN_LEN - 1);
  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk(prog_clk),
    .rst_n(pReset_n),
    .allow(allow),
    .nbits(nbits),
    .word_in(word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .take(take),
    .head(ccff_head),
    .clk_en(ccff_clk_en)
  );
  always_comb begin
    state_nx = restart ? LOAD :
               !last_bit ? state :
               (state == LOAD && VERIFY) ? CHECK :
               busy ? DONE : state;
  end
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) begin
      acc <= '0;
      bit_count <= '0;
      verify_err <= 1'b0;
    end else begin
      acc <= restart ? '0 : acc + AW'(take);
      bit_count <= restart ? '0 :
                   !ccff_clk_en ? bit_count :
                   last_bit ? (state_nx == CHECK ? '0 : CNT_W'(CHAIN_LEN)) :
                   bit_count + CNT_W'(1);
      verify_err <= restart ? 1'b0 :
                    verify_err | (VERIFY && state == CHECK && ccff_clk_en && ccff_tail != ccff_head);
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed scoreboard bench for single-pass and verify-pass chain loading
module tb_ccff_chain_loader;
  localparam int W = 8;
  localparam int N = 36;
  localparam int WORDS = (N + W - 1) / W;
  localparam int LAST = (N % W == 0) ? W : N % W;
  localparam logic [N-1:0] CHAIN_IMG = 36'hA53CFF009;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [W-1:0] word_in = '0;
  logic st0 = 1'b0, st1 = 1'b0, v0 = 1'b0, v1 = 1'b0;
  logic rdy0, rdy1, head0, head1, en0, en1, busy0, busy1, done0, done1, err0, err1;
  logic [5:0] bc0, bc1;
  logic [N-1:0] ch0, ch1;
  logic tail0, tail1;
  int len1 = N;
  logic [7:0] pat [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h9F};
  int errors = 0, checks = 0;
  logic q0 [$];
  logic q1 [$];
  int cyc = 0, en_n0 = 0, en_n1 = 0, wc0 = 0, wc1 = 0, first0 = -1, last0 = 0, acc0 = 0;
  logic exp_err1 = 1'b0;
  assign tail0 = ch0[N-1];
  assign tail1 = ch1[len1-1];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (en0) ch0 <= {ch0[N-2:0], head0};
    if (en1) ch1 <= {ch1[N-2:0], head1};
  end
  ccff_chain_loader #(.VERIFY(1'b0)) u0 (
    .prog_clk(clk), .pReset_n(rst_n), .start(st0), .word_in(word_in), .word_valid(v0),
    .word_ready(rdy0), .ccff_head(head0), .ccff_clk_en(en0), .ccff_tail(tail0),
    .busy(busy0), .done(done0), .verify_err(err0), .bit_count(bc0)
  );
  ccff_chain_loader #(.VERIFY(1'b1)) u1 (
    .prog_clk(clk), .pReset_n(rst_n), .start(st1), .word_in(word_in), .word_valid(v1),
    .word_ready(rdy1), .ccff_head(head1), .ccff_clk_en(en1), .ccff_tail(tail1),
    .busy(busy1), .done(done1), .verify_err(err1), .bit_count(bc1)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    logic e;
    @(negedge clk);
    cyc++;
    chk("bit_count0", bc0, (en_n0 < N) ? en_n0 : N);
    chk("bit_count1", bc1, (en_n1 < N) ? en_n1 : en_n1 - N);
    if (en0) begin
      if (first0 < 0) first0 = cyc;
      last0 = cyc;
      en_n0++;
      if (q0.size() == 0) chk("head0_unexpected_enable", en0, 1'b0);
      else begin
        e = q0.pop_front();
        chk("head0", head0, e);
      end
    end
    if (en1) begin
      chk("verify_err1", err1, exp_err1);
      if (q1.size() == 0) chk("head1_unexpected_enable", en1, 1'b0);
      else begin
        e = q1.pop_front();
        chk("head1", head1, e);
        if (en_n1 >= N && tail1 !== e) exp_err1 = 1'b1;
      end
      en_n1++;
    end
  endtask
  task automatic start_load(input bit d);
    if (d) begin
      st1 = 1'b1; en_n1 = 0; wc1 = 0; exp_err1 = 1'b0;
    end else begin
      st0 = 1'b1; en_n0 = 0; wc0 = 0; first0 = -1;
    end
    step();
    st0 = 1'b0;
    st1 = 1'b0;
  endtask
  task automatic send(input bit d, input logic [W-1:0] w);
    int n;
    int nb;
    n = 0;
    word_in = w;
    if (d) v1 = 1'b1; else v0 = 1'b1;
    while (!(d ? rdy1 : rdy0)) begin
      if (n == 100) begin
        chk("accept_timeout", d ? rdy1 : rdy0, 1'b1);
        v0 = 1'b0;
        v1 = 1'b0;
        return;
      end
      step();
      n++;
    end
    nb = (((d ? wc1 : wc0) % WORDS) == WORDS - 1) ? LAST : W;
    for (int i = 0; i < nb; i++)
      if (d) q1.push_back(w[W-1-i]); else q0.push_back(w[W-1-i]);
    if (d) wc1++;
    else begin
      if (wc0 == 0) acc0 = cyc;
      wc0++;
    end
    step();
    v0 = 1'b0;
    v1 = 1'b0;
  endtask
  task automatic wait_done(input bit d);
    int n;
    n = 0;
    while (!(d ? done1 : done0) && n < 300) begin
      step();
      n++;
    end
    chk("done", d ? done1 : done0, 1'b1);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset0", {rdy0, head0, en0, busy0, done0, err0, bc0}, '0);
    chk("reset1", {rdy1, head1, en1, busy1, done1, err1, bc1}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    start_load(0);
    for (int i = 0; i < WORDS; i++) send(0, pat[i]);
    wait_done(0);
    chk("s1_enables", en_n0, N);
    chk("s1_first_enable", first0, acc0 + 1);
    chk("s1_enable_span", last0 - first0 + 1, N);
    chk("s1_bit_count", bc0, N);
    chk("s1_chain", ch0, CHAIN_IMG);
    chk("s1_verify_err", err0, 1'b0);
    start_load(1);
    for (int i = 0; i < 2 * WORDS; i++) send(1, pat[i % WORDS]);
    wait_done(1);
    repeat (4) step();
    chk("s2_enables", en_n1, 2 * N);
    chk("s2_verify_err", err1, 1'b0);
    chk("s2_chain", ch1, CHAIN_IMG);
    len1 = N - 1;
    start_load(1);
    for (int i = 0; i < 2 * WORDS; i++) send(1, pat[i % WORDS]);
    wait_done(1);
    chk("s3_verify_err", err1, 1'b1);
    repeat (4) step();
    chk("s3_verify_err_held", err1, 1'b1);
    chk("s3_done_held", done1, 1'b1);
    len1 = N;
    start_load(0);
    send(0, pat[0]);
    send(0, pat[1]);
    for (int n = 0; n < 50 && !rdy0; n++) step();
    repeat (5) step();
    for (int i = 2; i < WORDS; i++) send(0, pat[i]);
    wait_done(0);
    chk("s4_enables", en_n0, N);
    chk("s4_enable_span", last0 - first0 + 1, N + 5);
    chk("s4_chain", ch0, CHAIN_IMG);
    start_load(0);
    for (int i = 0; i < 3; i++) send(0, pat[i]);
    for (int n = 0; n < 50 && en_n0 < 20; n++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_reset0", {rdy0, head0, en0, busy0, done0, err0, bc0}, '0);
    chk("s5_async_reset1", {rdy1, head1, en1, busy1, done1, err1, bc1}, '0);
    q0.delete();
    q1.delete();
    en_n0 = 0; en_n1 = 0; wc0 = 0; wc1 = 0; first0 = -1; exp_err1 = 1'b0;
    repeat (3) step();
    chk("s5_idle_after_reset", {busy0, done0, en0}, '0);
    rst_n = 1'b1;
    word_in = 8'h77;
    v0 = 1'b1;
    repeat (3) begin
      step();
      chk("s6_idle_ready", rdy0, 1'b0);
    end
    v0 = 1'b0;
    chk("s6_idle_queue", q0.size(), 0);
    start_load(0);
    send(0, pat[0]);
    send(0, pat[1]);
    st0 = 1'b1;
    send(0, pat[2]);
    st0 = 1'b0;
    for (int i = 3; i < WORDS; i++) send(0, pat[i]);
    wait_done(0);
    chk("s6_enables", en_n0, N);
    chk("s6_enable_span", last0 - first0 + 1, N);
    chk("s6_chain", ch0, CHAIN_IMG);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
